// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered 16-bit ripple-carry adder among
// NUM_REQ requesters; results return tagged with the owner's ID.
//
// state | meaning
// IDLE  | waiting for any req; grants round-robin from r_ptr
// EXEC  | operands registered, ack pulse high, adder evaluating
// DONE  | result held valid until result_ready

module adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [16:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[16];
endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   a_in,
  input  logic [16*NUM_REQ-1:0]   b_in,
  input  logic [NUM_REQ-1:0]      cin_in,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [15:0]             result_sum,
  output logic                    result_overflow,
  output logic [ID_W-1:0]         result_id,
  output logic                    busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [ID_W-1:0]     r_gid;
  logic [15:0]         r_op_a;
  logic [15:0]         r_op_b;
  logic                r_op_cin;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_valid;
  logic [15:0]         r_sum;
  logic                r_ovf;
  logic [ID_W-1:0]     r_id;

  logic                w_found;
  logic [PTR_W-1:0]    w_gnt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_onehot;
  logic [15:0]         w_sel_a;
  logic [15:0]         w_sel_b;
  logic                w_sel_cin;
  logic [15:0]         w_sum;
  logic                w_cout;
  int                  w_idx;

  // Search from r_ptr upward; the wrap subtracts rather than masks so that
  // non-power-of-2 requester counts stay in range.
  always_comb begin
    w_found   = 1'b0;
    w_gnt     = '0;
    w_onehot  = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found          = 1'b1;
        w_gnt            = PTR_W'(w_idx);
        w_onehot[w_idx]  = 1'b1;
        w_sel_a          = a_in[w_idx*16 +: 16];
        w_sel_b          = b_in[w_idx*16 +: 16];
        w_sel_cin        = cin_in[w_idx];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

  adder_16bit u_adder (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (r_op_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = DONE;
      DONE:    if (result_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_ack    <= '0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_op_cin <= w_sel_cin;
            r_gid    <= ID_W'(w_gnt);
            r_ack    <= w_onehot;
            r_ptr    <= w_ptr_nxt;
          end
        end
        EXEC: begin
          r_sum   <= w_sum;
          r_ovf   <= w_cout;
          r_id    <= r_gid;
          r_valid <= 1'b1;
          r_ack   <= '0;
        end
        DONE: begin
          if (result_ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack             = r_ack;
  assign result_valid    = r_valid;
  assign result_sum      = r_sum;
  assign result_overflow = r_ovf;
  assign result_id       = r_id;
  assign busy            = (r_state != IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a 4-requester instance and a
// 3-requester instance exercising the wrap of the round-robin pointer.

module tb_adder_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  cin_in;
  logic [3:0]  ack;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] result_sum;
  logic        result_overflow;
  logic [1:0]  result_id;
  logic        busy;

  logic [2:0]  req3;
  logic [47:0] a3;
  logic [47:0] b3;
  logic [2:0]  cin3;
  logic [2:0]  ack3;
  logic        valid3;
  logic        ready3;
  logic [15:0] sum3;
  logic        ovf3;
  logic [1:0]  id3;
  logic        busy3;

  int checks;
  int errors;
  int k;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .a_in            (a_in),
    .b_in            (b_in),
    .cin_in          (cin_in),
    .ack             (ack),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_sum      (result_sum),
    .result_overflow (result_overflow),
    .result_id       (result_id),
    .busy            (busy)
  );

  adder_share_arbiter #(.NUM_REQ(3), .ID_W(2)) dut3 (
    .clk             (clk),
    .rst             (rst),
    .req             (req3),
    .a_in            (a3),
    .b_in            (b3),
    .cin_in          (cin3),
    .ack             (ack3),
    .result_valid    (valid3),
    .result_ready    (ready3),
    .result_sum      (sum3),
    .result_overflow (ovf3),
    .result_id       (id3),
    .busy            (busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = '0; a_in = '0; b_in = '0; cin_in = '0; result_ready = 1'b0;
    req3 = '0; a3 = '0; b3 = '0; cin3 = '0; ready3 = 1'b1;
    tick();
    tick();
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'h0);
    chk("rst_sum",   32'(result_sum), 32'h0);
    chk("rst_ovf",   32'(result_overflow), 32'h0);
    chk("rst_id",    32'(result_id), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst3_valid", 32'(valid3), 32'h0);
    rst = 1'b0;

    // single request from requester 1
    a_in[31:16] = 16'h1234; b_in[31:16] = 16'h0F0F; cin_in[1] = 1'b1;
    req = 4'b0010;
    tick();
    chk("t1_ack",   32'(ack), 32'h2);
    chk("t1_busy",  32'(busy), 32'h1);
    chk("t1_early", 32'(result_valid), 32'h0);
    req = 4'b0000;
    a_in[31:16] = 16'hFFFF;
    tick();
    chk("t1_valid", 32'(result_valid), 32'h1);
    chk("t1_sum",   32'(result_sum), 32'h2144);
    chk("t1_ovf",   32'(result_overflow), 32'h0);
    chk("t1_id",    32'(result_id), 32'h1);
    chk("t1_ack0",  32'(ack), 32'h0);

    // backpressure with a pending request from requester 0
    a_in[15:0] = 16'hFFFF; b_in[15:0] = 16'h0001; cin_in[0] = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(result_valid), 32'h1);
      chk("bp_sum",   32'(result_sum), 32'h2144);
      chk("bp_id",    32'(result_id), 32'h1);
      chk("bp_busy",  32'(busy), 32'h1);
      chk("bp_ack",   32'(ack), 32'h0);
    end
    result_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(result_valid), 32'h0);
    chk("bp_release_ack",   32'(ack), 32'h0);
    chk("bp_release_busy",  32'(busy), 32'h0);
    tick();
    chk("ov1_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick();
    chk("ov1_valid", 32'(result_valid), 32'h1);
    chk("ov1_sum",   32'(result_sum), 32'h0000);
    chk("ov1_ovf",   32'(result_overflow), 32'h1);
    chk("ov1_id",    32'(result_id), 32'h0);

    a_in[15:0] = 16'h8000; b_in[15:0] = 16'h8000; cin_in[0] = 1'b1;
    req = 4'b0001;
    tick();
    chk("ov2_idle_ack", 32'(ack), 32'h0);
    tick();
    chk("ov2_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick();
    chk("ov2_sum", 32'(result_sum), 32'h0001);
    chk("ov2_ovf", 32'(result_overflow), 32'h1);
    tick();

    // 3-requester build: pointer wrap and a request raised during DONE
    a3[47:32] = 16'h0100; b3[47:32] = 16'h0023;
    req3 = 3'b100;
    tick();
    chk("w3_ack2", 32'(ack3), 32'h4);
    req3 = 3'b000;
    tick();
    chk("w3_id2",  32'(id3), 32'h2);
    chk("w3_sum2", 32'(sum3), 32'h0123);
    tick();
    a3[15:0]  = 16'h0001; b3[15:0]  = 16'h0002;
    a3[31:16] = 16'h0010; b3[31:16] = 16'h0020;
    req3 = 3'b011;
    tick();
    chk("w3_ack0", 32'(ack3), 32'h1);
    req3 = 3'b000;
    tick();
    chk("w3_id0",  32'(id3), 32'h0);
    chk("w3_sum0", 32'(sum3), 32'h0003);
    req3 = 3'b010;
    tick();
    chk("w3_late_noack", 32'(ack3), 32'h0);
    tick();
    chk("w3_ack1", 32'(ack3), 32'h2);
    req3 = 3'b000;
    tick();
    chk("w3_id1",  32'(id3), 32'h1);
    chk("w3_sum1", 32'(sum3), 32'h0030);
    tick();

    // fairness from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in[i*16 +: 16] = 16'(16'h1000 * i + 1);
      b_in[i*16 +: 16] = 16'h0010;
    end
    cin_in = 4'b0000;
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      k = n % 4;
      tick();
      chk("fair_ack", 32'(ack), 32'(1 << k));
      req[k] = 1'b0;
      tick();
      chk("fair_id",  32'(result_id), 32'(k));
      chk("fair_sum", 32'(result_sum), 32'(16'h1000 * k + 16'h0011));
      req = (n == 4) ? 4'h0 : 4'hF;
      tick();
      chk("fair_gap_valid", 32'(result_valid), 32'h0);
      chk("fair_gap_ack",   32'(ack), 32'h0);
    end

    // reset during EXEC
    a_in[47:32] = 16'h2001;
    req = 4'b0100;
    tick();
    chk("mid_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    rst = 1'b1;
    tick();
    chk("mid_valid", 32'(result_valid), 32'h0);
    chk("mid_ack0",  32'(ack), 32'h0);
    chk("mid_busy",  32'(busy), 32'h0);
    chk("mid_sum",   32'(result_sum), 32'h0);
    rst = 1'b0;
    req = 4'b1100;
    tick();
    chk("post_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    tick();
    chk("post_valid", 32'(result_valid), 32'h1);
    chk("post_id",    32'(result_id), 32'h2);
    chk("post_sum",   32'(result_sum), 32'h2011);
    tick();
    chk("post_idle", 32'(result_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one instance of the team's 16-bit ripple-carry adder (`adder_16bit`) among NUM_REQ requesters.
- Each requester presents operands and a carry-in. A round-robin arbiter grants one request at a time and registers that requester's operands into the adder.
- The registered sum/overflow is returned tagged with the requester ID, under a valid/ready handshake.
- Sits between client blocks and the shared arithmetic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of result_id; must be >= clog2(NUM_REQ)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; held high until the matching ack
- a_in  input  16*NUM_REQ  operand A, requester k on bits [16k+15:16k]
- b_in  input  16*NUM_REQ  operand B, same packing
- cin_in  input  NUM_REQ  per-requester carry-in
- ack  output  NUM_REQ  one-cycle registered pulse: operands of requester k captured
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- result_sum  output  16  registered sum
- result_overflow  output  1  carry-out of bit 15 (unsigned overflow)
- result_id  output  ID_W  index of requester owning the result
- busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, DONE. All registers update on the rising edge of clk; rst is synchronous.
- Reset values:
  - state = IDLE, ptr = 0, ack = 0, result_valid = 0, result_sum = 0x0000, result_overflow = 0, result_id = 0, busy = 0.
  - Operand registers are cleared to 0.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise, grant g = first set bit of req searched from ptr upward, wrapping modulo NUM_REQ.
  - At the edge: op_a <= a_in[g], op_b <= b_in[g], op_cin <= cin_in[g], gid <= g, ack[g] <= 1, state <= EXEC, ptr <= (g+1) mod NUM_REQ.
  - The wrap must be correct for non-power-of-2 NUM_REQ.
- EXEC (one cycle):
  - ack is high for exactly this cycle, one-hot at bit gid.
  - The adder sees only the registered operands (op_a, op_b, op_cin).
  - At the edge: result_sum <= adder sum, result_overflow <= adder overflow, result_id <= gid, result_valid <= 1, ack <= 0, state <= DONE.
- DONE:
  - result_valid stays high and result_* stay stable until result_ready is sampled high at an edge.
  - On that edge: result_valid <= 0, state <= IDLE.
  - No new grant is issued in the same cycle.
- Latency and throughput:
  - req sampled in IDLE at edge t gives ack high during cycle t+1 and result_valid high from cycle t+2.
  - Minimum issue interval is 3 cycles per operation with result_ready held high.
- Arithmetic:
  - Unsigned: {result_overflow, result_sum} = op_a + op_b + op_cin (17-bit).
  - Operands are registered before the adder, so sum and overflow never come from the unregistered a_in/b_in/cin_in.
- Request rules:
  - req is sampled only in IDLE.
  - A req asserted during EXEC/DONE waits for the next IDLE.
  - A req deasserted after grant does not cancel the operation.
  - Changes to a_in/b_in/cin_in after capture do not affect the result.
  - A requester must drop req the cycle after seeing ack, or it is eligible for regrant; it then has lowest priority because ptr has advanced past it.
- Simultaneous requests: round-robin guarantees each active requester is granted within NUM_REQ operations.
- result_ready high while result_valid is low: ignored.
- Reset mid-operation (EXEC or DONE):
  - The operation is aborted and no result is delivered.
  - All outputs take their reset values on the next cycle; ptr returns to 0.

Test Plan:
- Single request: only req[1] with a=0x1234, b=0x0F0F, cin=1 -> ack=4'b0010 one cycle later; result_valid two cycles after sampling; result_sum=0x2144, result_overflow=0, result_id=1.
- Overflow: req[0] with a=0xFFFF, b=0x0001, cin=0 -> result_sum=0x0000, result_overflow=1; with a=0x8000, b=0x8000, cin=1 -> result_sum=0x0001, result_overflow=1.
- Fairness: from reset, req=4'b1111 held, each requester drops req for one cycle after its ack and then reasserts, result_ready=1 -> result_id sequence 0,1,2,3,0; one ack every 3 cycles.
- Backpressure: result_ready=0 for 5 cycles after result_valid -> result_valid and result_* stable all 5 cycles, busy=1, no further ack; result_ready=1 -> result_valid=0 next cycle, then the next grant proceeds.
- Reset mid-op: assert rst in the EXEC cycle -> next cycle result_valid=0, ack=0, busy=0, ptr=0; a subsequent req=4'b1100 is granted to requester 2.
- Pointer wrap and late request: NUM_REQ=3 build, grant requester 2, then req=3'b011 -> requester 0 granted first; a req[1] raised during DONE is not acked until after return to IDLE.
